// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmit-channel address arbiter.
package tx_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Default channel address width.
    localparam int ADDR_W_DEF = 11;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after
// ptr_i (wrapping) wins. Reports whether any request won, the one-hot
// winner and its index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [PTR_W-1:0]   idx_o
);

    int               k;
    logic [PTR_W-1:0] kk;

    // Walk the requests starting at the pointer; the first hit is kept.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx_o    = '0;
        k        = 0;
        kk       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kk = PTR_W'(k);
            if (!valid_o && req_i[kk]) begin
                valid_o      = 1'b1;
                winner_o[kk] = 1'b1;
                idx_o        = kk;
            end
        end
    end

endmodule

// File: rtl/tx_addr_arbiter.sv
// Round-robin arbiter that shares one transmit/receive channel between
// NUM_REQ requesters. It launches the winner's address with a one-cycle
// start pulse, follows the channel's active-low ready through accept
// (ready rises) and completion (ready falls), then pulses done to the winner.
// Optional feature macro: TX_ARB_TIMEOUT_EN -- bounds each wait state to
// TIMEOUT cycles and reports an expired wait with an err pulse.
// Handshake: a requester holds req high until it sees its done or err
// pulse; grant stays high from launch until the transaction ends.
module tx_addr_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      start,
    output logic [ADDR_W-1:0]         address_bus,
    input  logic                      ready,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 start_q, start_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 busy_q, busy_d;

    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    win_addr;
    logic [PTR_W-1:0]     ptr_next;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // Select the winner's address slice and the pointer just past it.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        ptr_next = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        start_d = 1'b0;
        addr_d  = addr_q;
`ifdef TX_ARB_TIMEOUT_EN
        err_d   = '0;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Launch only while the channel reports idle.
                if (pick_valid && !ready) begin
                    state_d = LAUNCH;
                    grant_d = pick_onehot;
                    start_d = 1'b1;
                    addr_d  = win_addr;
                    ptr_d   = ptr_next;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACK;
`ifdef TX_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_ACK: begin
                if (ready) begin
                    state_d = WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    addr_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            WAIT_DONE: begin
                if (!ready) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    addr_d  = '0;
                    state_d = IDLE;
`ifdef TX_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    addr_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                addr_d  = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
`ifdef TX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign start       = start_q;
    assign address_bus = addr_q;
    assign busy        = busy_q;
`ifdef TX_ARB_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = '0;
`endif

endmodule

// File: tb/tb_tx_addr_arbiter.sv
// Directed testbench for tx_addr_arbiter (NUM_REQ=4, ADDR_W=11, TIMEOUT=8).
module tb_tx_addr_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic            start;
    logic [AW-1:0]   address_bus;
    logic            ready;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    tx_addr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .TIMEOUT (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .start       (start),
        .address_bus (address_bus),
        .ready       (ready),
        .busy        (busy)
    );

    // Clock
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Wait (bounded) for the start pulse.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(start), 32'd1);
    endtask

    // Channel model, called in the LAUNCH cycle: accept next cycle, stay
    // busy for hi edges, then go idle. Done is visible on return.
    task automatic channel(input int hi);
        tick();
        ready = 1'b1;
        repeat (hi) tick();
        ready = 1'b0;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        ready    = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_addr",  32'(address_bus), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_busy",  32'(busy),  32'd0);
        check("idle_grant", 32'(grant), 32'd0);

        // Single request from requester 1
        set_addr(1, 11'h2A5);
        req = 4'b0010;
        tick();
        check("single_grant", 32'(grant), 32'h2);
        check("single_start", 32'(start), 32'd1);
        check("single_addr",  32'(address_bus), 32'h2A5);
        check("single_busy",  32'(busy), 32'd1);
        tick();
        check("single_start_low", 32'(start), 32'd0);
        check("single_addr_hold", 32'(address_bus), 32'h2A5);
        ready = 1'b1;
        repeat (3) tick();
        check("single_no_early_done", 32'(done), 32'd0);
        ready = 1'b0;
        tick();
        check("single_done",  32'(done),  32'h2);
        check("single_grant_clr", 32'(grant), 32'd0);
        check("single_busy_low",  32'(busy),  32'd0);
        req = '0;
        tick();
        check("single_done_pulse", 32'(done), 32'd0);

        // Fairness: all request, pointer back at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(11'h100 + i));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start("fair");
            check("fair_grant", 32'(grant), 32'(1 << (i % 4)));
            check("fair_addr",  32'(address_bus), 32'(11'h100 + (i % 4)));
            channel(2);
            check("fair_done", 32'(done), 32'(1 << (i % 4)));
            check("fair_no_overlap", 32'(start), 32'd0);
        end
        req = '0;
        repeat (2) tick();

        // Channel busy externally; pointer now 1, only requester 0 asks
        ready = 1'b1;
        req   = 4'b0001;
        repeat (3) tick();
        check("ext_grant", 32'(grant), 32'd0);
        check("ext_start", 32'(start), 32'd0);
        check("ext_busy",  32'(busy),  32'd0);
        ready = 1'b0;
        tick();
        check("ext_start_go", 32'(start), 32'd1);
        check("ext_grant_go", 32'(grant), 32'h1);
        channel(1);
        check("ext_done", 32'(done), 32'h1);
        req = '0;
        tick();

        // Reset mid-transaction; pointer is 1 so requester 2 wins first
        set_addr(2, 11'h155);
        set_addr(3, 11'h3AA);
        req = 4'b1100;
        wait_start("midrst");
        check("midrst_grant", 32'(grant), 32'h4);
        tick();
        ready = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("midrst_grant0", 32'(grant), 32'd0);
        check("midrst_start0", 32'(start), 32'd0);
        check("midrst_busy0",  32'(busy),  32'd0);
        check("midrst_addr0",  32'(address_bus), 32'd0);
        check("midrst_done0",  32'(done),  32'd0);
        ready = 1'b0;
        tick();
        check("midrst_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        // Pointer restarted at 0: requester 2 wins again over 3
        check("midrst_regrant", 32'(grant), 32'h4);
        check("midrst_restart", 32'(start), 32'd1);
        check("midrst_addr",    32'(address_bus), 32'h155);
        channel(1);
        check("midrst_done", 32'(done), 32'h4);

        // Requester 3 next; drop req and change address after grant
        req = 4'b1000;
        tick();
        check("drop_grant", 32'(grant), 32'h8);
        check("drop_addr",  32'(address_bus), 32'h3AA);
        req = '0;
        set_addr(3, 11'h7FF);
        tick();
        check("drop_addr_hold1", 32'(address_bus), 32'h3AA);
        check("drop_grant_hold", 32'(grant), 32'h8);
        ready = 1'b1;
        tick();
        check("drop_addr_hold2", 32'(address_bus), 32'h3AA);
        ready = 1'b0;
        tick();
        check("drop_done", 32'(done), 32'h8);
        tick();
        check("drop_done_pulse", 32'(done), 32'd0);
        check("drop_idle", 32'(busy), 32'd0);

`ifdef TX_ARB_TIMEOUT_EN
        // Ready never rises: err after 8 cycles in WAIT_ACK
        req = 4'b0001;
        wait_start("tmo");
        check("tmo_grant", 32'(grant), 32'h1);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_err_early", 32'(err), 32'd0);
        end
        tick();
        check("tmo_err",   32'(err),   32'h1);
        check("tmo_grant_clr", 32'(grant), 32'd0);
        check("tmo_no_done",   32'(done),  32'd0);
        req = 4'b0010;
        tick();
        check("tmo_next_grant", 32'(grant), 32'h2);
        channel(1);
        check("tmo_next_done", 32'(done), 32'h2);
        req = '0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
